// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall controller for the 5-stage MIPS pipeline. Produces the
//   register enables and bubble/NOP flushes for PC, IF_ID, ID_EX, EX_MEM and
//   MEM_WB from three hazard sources:
//     - cache freezes (ICache_stall / DCache_stall): whole pipeline holds
//     - taken branch resolved in MEM: three younger stages are squashed
//     - load-use: one bubble into ID_EX while PC and IF_ID hold
//   A RUN/WAIT/ERR wait-state FSM counts consecutive frozen cycles and raises a
//   sticky timeout once a freeze lasts longer than MAX_WAIT cycles.
//
// Parameters
//   MAX_WAIT  consecutive frozen cycles tolerated before timeout (1..65535)
//   CNT_W     width of the wait counter, must hold MAX_WAIT
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   ID_rs, ID_rt, ID_use_rt  source registers of the instruction in ID
//   EX_MemRead, EX_rt      lw in EX and its destination register
//   MEM_branch_taken       beq in MEM with zero=1
//   ICache_stall, DCache_stall  cache busy handshakes
//   *_write, *_flush       pipeline register enables / bubble loads
//   timeout                sticky watchdog flag, cleared only by rst
//   dbg_state              current FSM state (RUN=0, WAIT=1, ERR=2)
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters
//   perf_freeze (frozen cycles), perf_flush (branch flush cycles) and
//   perf_bubble (load-use bubble cycles).
//
// Handshake: a cache holds its stall high for as long as it is busy; every
//   cycle with either stall high is one frozen cycle, and the controller
//   releases the pipeline in the same cycle the stall drops.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_use_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       MEM_branch_taken,
    input  logic       ICache_stall,
    input  logic       DCache_stall,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       ID_EX_write,
    output logic       EX_MEM_write,
    output logic       MEM_WB_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
    output logic       timeout,
    output logic [1:0] dbg_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_freeze,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_bubble
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             timeout_nxt;

    logic freeze;
    logic lu;
    logic br;

    assign freeze = ICache_stall | DCache_stall;
    assign br     = MEM_branch_taken;
    // Register 0 is hardwired to zero, so a lw targeting it never creates a
    // real dependency.
    assign lu     = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_use_rt && (EX_rt == ID_rt)));

    assign dbg_state = state;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = timeout;
        unique case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!freeze) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == MAX_CNT) begin
                    state_nxt   = ERR;
                    timeout_nxt = 1'b1;
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ERR: begin
                // Counter stays parked at MAX_WAIT while the freeze persists.
                if (!freeze) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // ---------------- pipeline controls (same-cycle) ----------------
    // The FSM does not gate the controls: even in ERR the pipeline keeps
    // obeying the caches, so only rst and the hazard priority matter here.
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        if (rst || freeze) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
        end else if (br) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (lu) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_freeze <= '0;
            perf_flush  <= '0;
            perf_bubble <= '0;
        end else begin
            if (freeze && (perf_freeze != '1))
                perf_freeze <= perf_freeze + 32'd1;
            if (!freeze && br && (perf_flush != '1))
                perf_flush <= perf_flush + 32'd1;
            if (!freeze && !br && lu && (perf_bubble != '1))
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 4;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_rt;
    logic       ID_use_rt, EX_MemRead, MEM_branch_taken;
    logic       ICache_stall, DCache_stall;
    logic       PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush;
    logic       timeout;
    logic [1:0] dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_freeze, perf_flush, perf_bubble;
`endif

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rt(ID_use_rt),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .MEM_branch_taken(MEM_branch_taken),
        .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
        .MEM_WB_write(MEM_WB_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush),
        .timeout(timeout), .dbg_state(dbg_state)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_freeze(perf_freeze), .perf_flush(perf_flush),
        .perf_bubble(perf_bubble)
`endif
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // The watchdog is modelled as "length of the current run of frozen
    // cycles": 0 -> RUN, 1..MAX_WAIT -> WAIT, beyond -> ERR.
    int          run_len;
    bit          exp_timeout;
    bit          model_valid = 1'b0;
    int unsigned m_freeze, m_flush, m_bubble;

    function automatic bit load_use();
        return EX_MemRead && EX_rt != 0 &&
               (EX_rt == ID_rs || (ID_use_rt && EX_rt == ID_rt));
    endfunction

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, EX_MEM flushes}
    function automatic logic [7:0] exp_ctl();
        bit frz;
        frz = ICache_stall || DCache_stall;
        if (rst || frz)            return 8'b00000_000;
        else if (MEM_branch_taken) return 8'b11111_111;
        else if (load_use())       return 8'b00111_010;
        else                       return 8'b11111_000;
    endfunction

    function automatic logic [1:0] exp_state();
        if (run_len == 0)             return 2'd0;
        else if (run_len <= MAX_WAIT) return 2'd1;
        else                          return 2'd2;
    endfunction

    task automatic model_edge();
        bit frz;
        frz = ICache_stall || DCache_stall;
        if (rst) begin
            run_len = 0; exp_timeout = 0; model_valid = 1'b1;
            m_freeze = 0; m_flush = 0; m_bubble = 0;
        end else begin
            if (frz) begin
                if (run_len < 1000000) run_len++;
                if (run_len > MAX_WAIT) exp_timeout = 1;
                m_freeze++;
            end else begin
                run_len = 0;
                if (MEM_branch_taken) m_flush++;
                else if (load_use()) m_bubble++;
            end
        end
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag);
        logic [7:0] obs_ctl, e_ctl;
        obs_ctl = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
                   IF_ID_flush, ID_EX_flush, EX_MEM_flush};
        e_ctl = exp_ctl();
        checks++;
        assert (obs_ctl === e_ctl) else begin
            errors++;
            $error("FAIL %s ctl: observed=%b expected=%b", tag, obs_ctl, e_ctl);
        end
        if (model_valid) begin
            checks++;
            assert (timeout === exp_timeout) else begin
                errors++;
                $error("FAIL %s timeout: observed=%b expected=%b", tag, timeout, exp_timeout);
            end
            checks++;
            assert (dbg_state === exp_state()) else begin
                errors++;
                $error("FAIL %s state: observed=%0d expected=%0d", tag, dbg_state, exp_state());
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            assert (perf_freeze === m_freeze && perf_flush === m_flush &&
                    perf_bubble === m_bubble) else begin
                errors++;
                $error("FAIL %s perf: observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
                       perf_freeze, perf_flush, perf_bubble, m_freeze, m_flush, m_bubble);
            end
`endif
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after posedge; checks happen at the
    // following negedge, and the model advances on the posedge.
    task automatic tick(input string tag);
        #4;
        check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit r, input int rs, input int rt, input bit use_rt,
                         input bit mrd, input int ert, input bit br,
                         input bit ic, input bit dc, input string tag);
        rst = r; ID_rs = 5'(rs); ID_rt = 5'(rt); ID_use_rt = use_rt;
        EX_MemRead = mrd; EX_rt = 5'(ert); MEM_branch_taken = br;
        ICache_stall = ic; DCache_stall = dc;
        tick(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int burst;
        bit b_ic, b_dc;
        run_len = 0; exp_timeout = 0;
        m_freeze = 0; m_flush = 0; m_bubble = 0;
        @(posedge clk); #1;

        // Reset, then idle
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle0");
        drive(0, 3, 4, 1, 0, 0, 0, 0, 0, "idle1");

        // Load-use on rs, then the lw moves on
        drive(0, 8, 9, 1, 1, 8, 0, 0, 0, "lu_rs");
        drive(0, 8, 9, 1, 0, 0, 0, 0, 0, "lu_clear");
        drive(0, 0, 9, 1, 1, 0, 0, 0, 0, "lu_r0");
        drive(0, 5, 9, 1, 1, 9, 0, 0, 0, "lu_rt");
        drive(0, 5, 9, 0, 1, 9, 0, 0, 0, "lu_rt_unused");

        // Branch beats a simultaneous load-use
        drive(0, 8, 9, 1, 1, 8, 1, 0, 0, "br_lu");

        // DCache freeze with branch pending, then branch fires
        for (int i = 0; i < 5; i++)
            drive(0, 1, 2, 1, 0, 0, 1, 0, 1, "dstall_br");
        drive(0, 1, 2, 1, 0, 0, 1, 0, 0, "br_release");
        drive(0, 1, 2, 1, 0, 0, 0, 1, 1, "both_stall");
        drive(0, 1, 2, 1, 0, 0, 0, 0, 0, "after_both");

        // Watchdog: 10 frozen cycles, timeout after the 5th
        for (int i = 0; i < 10; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "watchdog");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, "err_release_br");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "tmo_sticky");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "rewait0");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "rewait1");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "rst_mid_wait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");

        // Randomized traffic with stall bursts and occasional resets
        burst = 0; b_ic = 0; b_dc = 0;
        for (int i = 0; i < 600; i++) begin
            if (burst == 0 && $urandom_range(0, 7) == 0) begin
                burst = $urandom_range(1, 8);
                b_ic = 1'($urandom_range(0, 1));
                b_dc = b_ic ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0,
                  burst != 0 && b_ic, burst != 0 && b_dc, "random");
            if (burst != 0) burst--;
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "final_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
